md_sched: RTL and testbench

Sequencer and state holder for the HI/LO multiply/divide unit in the pipelined MIPS core. It sits beside the E-stage ALU and accepts a 4-bit operation code and two operands from the E stage. It models the multi-cycle latency of mult/multu/msub/div/divu and commits results to HI/LO when that latency expires. It serves mfhi/mflo reads and mthi/mtlo writes, and drives the D-stage stall when an HI/LO-touching instruction would collide with an in-flight operation.

---
 rtl/md_sched.sv | 138 +++++++++++++
 tb/tb_md_sched.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// ============================================================================
// Module   : md_sched
// Brief    : HI/LO multiply/divide sequencer with latency model and D-stall.
// Revision : 1.0
// ============================================================================
`default_nettype none

module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        d_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] md_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] c_mult_cnt = 4'(MULT_CYCLES);
    localparam logic [3:0] c_div_cnt  = 4'(DIV_CYCLES);

    localparam logic [3:0] c_op_mult  = 4'd1;
    localparam logic [3:0] c_op_multu = 4'd2;
    localparam logic [3:0] c_op_div   = 4'd3;
    localparam logic [3:0] c_op_divu  = 4'd4;
    localparam logic [3:0] c_op_mtlo  = 4'd5;
    localparam logic [3:0] c_op_mthi  = 4'd6;
    localparam logic [3:0] c_op_mflo  = 4'd7;
    localparam logic [3:0] c_op_mfhi  = 4'd8;
    localparam logic [3:0] c_op_msub  = 4'd9;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [3:0]         r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [63:0]        r_pend;
    logic               r_pend_en;
    logic               r_sub;

    logic               w_is_mul;
    logic               w_is_div;
    logic               w_launch;
    logic               w_done;
    logic [31:0]        w_divisor;
    logic signed [63:0] w_smul;
    logic [63:0]        w_umul;
    logic signed [31:0] w_sq;
    logic signed [31:0] w_sr;
    logic [31:0]        w_uq;
    logic [31:0]        w_ur;
    logic [63:0]        w_result;

    assign w_is_mul = (op == c_op_mult) || (op == c_op_multu) || (op == c_op_msub);
    assign w_is_div = (op == c_op_div) || (op == c_op_divu);
    assign w_launch = (r_state == S_IDLE) && start && (w_is_mul || w_is_div);
    assign w_done   = (r_state == S_RUN) && (r_cnt <= 4'd1);

    // Divisor forced to 1 on b == 0 so the divider never sees zero; the
    // commit-enable suppresses the meaningless result in that case.
    assign w_divisor = (b == 32'd0) ? 32'd1 : b;
    assign w_smul    = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_umul    = {32'd0, a} * {32'd0, b};
    assign w_sq      = $signed(a) / $signed(w_divisor);
    assign w_sr      = $signed(a) % $signed(w_divisor);
    assign w_uq      = a / w_divisor;
    assign w_ur      = a % w_divisor;

    always_comb begin
        w_result = 64'd0;
        case (op)
            c_op_mult, c_op_msub: w_result = w_smul;
            c_op_multu:           w_result = w_umul;
            c_op_div:             w_result = {w_sr, w_sq};
            c_op_divu:            w_result = {w_ur, w_uq};
            default:              w_result = 64'd0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_launch) w_next_state = S_RUN;
            S_RUN:   if (w_done)   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= 4'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend    <= 64'd0;
            r_pend_en <= 1'b0;
            r_sub     <= 1'b0;
        end else if (w_launch) begin
            r_cnt     <= w_is_div ? c_div_cnt : c_mult_cnt;
            r_pend    <= w_result;
            r_pend_en <= !(w_is_div && (b == 32'd0));
            r_sub     <= (op == c_op_msub);
        end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt - 4'd1;
            // msub reads HI/LO here; they are frozen for the whole busy period.
            if (w_done && r_pend_en) begin
                {r_hi, r_lo} <= r_sub ? ({r_hi, r_lo} - r_pend) : r_pend;
            end
        end else if (!start && (op == c_op_mtlo)) begin
            r_lo <= a;
        end else if (!start && (op == c_op_mthi)) begin
            r_hi <= a;
        end
    end

    assign busy   = (r_state == S_RUN);
    assign stall  = d_md & (start | busy);
    assign md_out = (op == c_op_mflo) ? r_lo :
                    (op == c_op_mfhi) ? r_hi : 32'd0;
    assign hi     = r_hi;
    assign lo     = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_md_sched.sv
// ============================================================================
// Module   : tb_md_sched
// Brief    : Directed self-checking bench for md_sched.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_md_sched;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        d_md;
    logic        busy;
    logic        stall;
    logic [31:0] md_out;
    logic [31:0] hi;
    logic [31:0] lo;

    int compared = 0;
    int mismatched = 0;

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .d_md   (d_md),
        .busy   (busy),
        .stall  (stall),
        .md_out (md_out),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one op and count busy cycles (bounded).
    task automatic launch(input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bb,
                          input int n_exp, input string tag);
        int n;
        op = o; a = aa; b = bb; start = 1'b1;
        tick;
        start = 1'b0; op = 4'd0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick;
        end
        check({tag, " busy cycles"}, 32'(n), 32'(n_exp));
    endtask

    task automatic write_hilo(input logic [3:0] o, input logic [31:0] aa);
        op = o; a = aa;
        tick;
        op = 4'd0;
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0; d_md = 1'b0;
        tick; tick;
        reset = 1'b0;
        #1;
        check("reset busy",   {31'd0, busy},  32'd0);
        check("reset stall",  {31'd0, stall}, 32'd0);
        check("reset hi",     hi, 32'd0);
        check("reset lo",     lo, 32'd0);
        check("reset md_out", md_out, 32'd0);

        launch(4'd1, 32'hFFFFFFFE, 32'd3, 5, "mult");
        check("mult hi", hi, 32'hFFFFFFFF);
        check("mult lo", lo, 32'hFFFFFFFA);

        launch(4'd2, 32'hFFFFFFFE, 32'd3, 5, "multu");
        check("multu hi", hi, 32'h00000002);
        check("multu lo", lo, 32'hFFFFFFFA);

        launch(4'd3, 32'hFFFFFFF9, 32'd2, 10, "div");
        check("div lo", lo, 32'hFFFFFFFD);
        check("div hi", hi, 32'hFFFFFFFF);

        launch(4'd4, 32'd7, 32'd2, 10, "divu");
        check("divu lo", lo, 32'd3);
        check("divu hi", hi, 32'd1);

        write_hilo(4'd5, 32'h22);
        write_hilo(4'd6, 32'h11);
        check("mtlo lo", lo, 32'h22);
        check("mthi hi", hi, 32'h11);
        launch(4'd4, 32'd9, 32'd0, 10, "divu0");
        check("divu0 hi", hi, 32'h11);
        check("divu0 lo", lo, 32'h22);

        write_hilo(4'd5, 32'd10);
        write_hilo(4'd6, 32'd0);
        launch(4'd9, 32'd2, 32'd3, 5, "msub1");
        check("msub1 lo", lo, 32'd4);
        check("msub1 hi", hi, 32'd0);
        launch(4'd9, 32'd1, 32'd5, 5, "msub2");
        check("msub2 hi", hi, 32'hFFFFFFFF);
        check("msub2 lo", lo, 32'hFFFFFFFF);

        // Stall sequence with an HI/LO instruction in D throughout.
        d_md = 1'b1; op = 4'd1; a = 32'd7; b = 32'd6; start = 1'b1;
        #1;
        check("stall at start", {31'd0, stall}, 32'd1);
        tick;
        start = 1'b0; op = 4'd0;
        n = 0;
        while (busy && n < 40) begin
            check("stall busy", {31'd0, stall}, 32'd1);
            n++;
            tick;
        end
        check("stall busy cycles", 32'(n), 32'd5);
        check("stall released", {31'd0, stall}, 32'd0);
        op = 4'd7;
        #1;
        check("mflo", md_out, 32'd42);
        op = 4'd8;
        #1;
        check("mfhi", md_out, 32'd0);
        op = 4'd0; d_md = 1'b0;
        tick;

        // Misuse: mthi and a second start during busy are both ignored.
        op = 4'd1; a = 32'h00010000; b = 32'h00010000; start = 1'b1;
        tick;
        start = 1'b0; op = 4'd6; a = 32'h55;
        tick;
        op = 4'd3; a = 32'd100; b = 32'd7; start = 1'b1;
        tick;
        start = 1'b0; op = 4'd0;
        n = 2;
        while (busy && n < 40) begin
            n++;
            tick;
        end
        check("misuse busy cycles", 32'(n), 32'd5);
        check("misuse hi", hi, 32'd1);
        check("misuse lo", lo, 32'd0);

        // Reset in the third busy cycle of a div.
        op = 4'd3; a = 32'd100; b = 32'd7; start = 1'b1;
        tick;
        start = 1'b0; op = 4'd0;
        tick;
        tick;
        check("pre-reset busy", {31'd0, busy}, 32'd1);
        reset = 1'b1; d_md = 1'b1;
        tick;
        reset = 1'b0;
        #1;
        check("post-reset busy",  {31'd0, busy},  32'd0);
        check("post-reset stall", {31'd0, stall}, 32'd0);
        check("post-reset hi", hi, 32'd0);
        check("post-reset lo", lo, 32'd0);
        d_md = 1'b0;
        repeat (15) tick;
        check("no late commit hi", hi, 32'd0);
        check("no late commit lo", lo, 32'd0);
        check("no late busy", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
